// File: rtl/fmaadd_pipe.sv
// Pipelined FMA addition stage: adds the aligned addend to the product and returns sign/magnitude.
// Optional leading-zero count of the sum is built when FMAADD_LZC_EN is defined.
module fmaadd_pipe #(
    parameter int unsigned NF     = 52,
    parameter int unsigned NE     = 11,
    parameter int unsigned STAGES = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic                      Flush,
    input  logic [3*NF+5:0]           Am,
    input  logic [2*NF+1:0]           Pm,
    input  logic [NE-1:0]             Ze,
    input  logic [NE+1:0]             Pe,
    input  logic                      Ps,
    input  logic                      InvA,
    input  logic                      KillProd,
    input  logic                      ASticky,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [3*NF+5:0]           Sm,
    output logic                      Ss,
    output logic [NE+1:0]             Se
`ifdef FMAADD_LZC_EN
    ,
    output logic [$clog2(3*NF+7)-1:0] SmLzc
`endif
);

    localparam int unsigned W   = 3*NF + 6;
    localparam int unsigned W1  = W + 1;
    localparam int unsigned H   = (W + 1) / 2;
    localparam int unsigned HP1 = H + 1;
    localparam int unsigned WH1 = W + 1 - H;
    localparam int unsigned WH2 = W - H;
    localparam int unsigned LW  = $clog2(W + 1);

    // Stage-1 payload: finished low halves with carries, raw high halves, controls.
    typedef struct packed {
        logic [WH1-1:0] xh;
        logic [WH1-1:0] yh;
        logic [WH2-1:0] ah;
        logic [WH2-1:0] bh;
        logic [H-1:0]   lo1;
        logic           c1;
        logic [H-1:0]   lo2;
        logic           c2;
        logic           ps;
        logic [NE+1:0]  se;
    } s1_t;

    logic [2*NF+1:0] pmk;
    logic [W-1:0]    ami;
    logic [W-1:0]    b2;
    logic [W:0]      x1;
    logic [W:0]      y1;
    logic            cin1;
    logic            k2;
    logic [H:0]      lo1_sum;
    logic [H:0]      lo2_sum;
    s1_t             s1_d;
    s1_t             s1_q;

    logic [WH1-1:0]  hi1;
    logic [WH2-1:0]  hi2;
    logic            negsum;
    logic [W-1:0]    sm_c;
    logic            ss_c;

    logic            adv2;
    logic            feed;

`ifdef FMAADD_LZC_EN
    function automatic logic [LW-1:0] lzc(input logic [W-1:0] v);
        lzc = LW'(W);
        for (int i = 0; i < int'(W); i++) begin
            if (v[i]) lzc = LW'(int'(W) - 1 - i);
        end
    endfunction
`endif

    // Low halves of the true sum and of the negated sum, plus operand high halves.
    always_comb begin
        pmk     = KillProd ? '0 : Pm;
        ami     = InvA ? ~Am : Am;
        x1      = W1'({pmk, 2'b00});
        y1      = {InvA, ami};
        cin1    = (~ASticky | KillProd) & InvA;
        b2      = {{(NF+2){1'b1}}, ~pmk, 2'b00};
        k2      = ~ASticky | ~KillProd;
        lo1_sum = {1'b0, x1[H-1:0]} + {1'b0, y1[H-1:0]} + HP1'(cin1);
        lo2_sum = {1'b0, Am[H-1:0]} + {1'b0, b2[H-1:0]} + {{(H-2){1'b0}}, k2, 2'b00};
        s1_d.xh  = x1[W:H];
        s1_d.yh  = y1[W:H];
        s1_d.ah  = Am[W-1:H];
        s1_d.bh  = b2[W-1:H];
        s1_d.lo1 = lo1_sum[H-1:0];
        s1_d.c1  = lo1_sum[H];
        s1_d.lo2 = lo2_sum[H-1:0];
        s1_d.c2  = lo2_sum[H];
        s1_d.ps  = Ps;
        s1_d.se  = KillProd ? {2'b00, Ze} : Pe;
    end

    // High halves; the carry out of the true sum decides which sum is the magnitude.
    always_comb begin
        hi1    = s1_q.xh + s1_q.yh + WH1'(s1_q.c1);
        hi2    = s1_q.ah + s1_q.bh + WH2'(s1_q.c2);
        negsum = hi1[WH1-1];
        sm_c   = negsum ? {hi2, s1_q.lo2} : {hi1[WH1-2:0], s1_q.lo1};
        ss_c   = negsum ^ s1_q.ps;
    end

    assign adv2 = ~OutValid | OutReady;

    generate
        if (STAGES == 2) begin : g_two
            logic v1;

            assign InReady = ~v1 | adv2;
            assign feed    = v1;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v1   <= 1'b0;
                    s1_q <= '0;
                end else if (Flush) begin
                    v1 <= 1'b0;
                end else if (~v1 | adv2) begin
                    v1 <= InValid;
                    if (InValid) s1_q <= s1_d;
                end
            end
        end else begin : g_one
            assign InReady = adv2;
            assign feed    = InValid;
            assign s1_q    = s1_d;
        end
    endgenerate

    // Output stage holds its contents whenever downstream stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            OutValid <= 1'b0;
            Sm       <= '0;
            Ss       <= 1'b0;
            Se       <= '0;
`ifdef FMAADD_LZC_EN
            SmLzc    <= '0;
`endif
        end else if (Flush) begin
            OutValid <= 1'b0;
        end else if (adv2) begin
            OutValid <= feed;
            if (feed) begin
                Sm    <= sm_c;
                Ss    <= ss_c;
                Se    <= s1_q.se;
`ifdef FMAADD_LZC_EN
                SmLzc <= lzc(sm_c);
`endif
            end
        end
    end

endmodule

// File: tb/tb_fmaadd_pipe.sv
// Directed self-checking bench for fmaadd_pipe (NF=23, NE=8, STAGES=2).
module tb_fmaadd_pipe;

    localparam int NF     = 23;
    localparam int NE     = 8;
    localparam int STAGES = 2;
    localparam int W      = 3*NF + 6;
    localparam int PW     = 2*NF + 2;
    localparam int EW     = NE + 2;
    localparam int LW     = $clog2(W + 1);

    logic          clk;
    logic          reset;
    logic          InValid;
    logic          InReady;
    logic          Flush;
    logic [W-1:0]  Am;
    logic [PW-1:0] Pm;
    logic [NE-1:0] Ze;
    logic [EW-1:0] Pe;
    logic          Ps;
    logic          InvA;
    logic          KillProd;
    logic          ASticky;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  Sm;
    logic          Ss;
    logic [EW-1:0] Se;
`ifdef FMAADD_LZC_EN
    logic [LW-1:0] SmLzc;
`endif

    int checks;
    int failures;

    fmaadd_pipe #(.NF(NF), .NE(NE), .STAGES(STAGES)) dut (
        .clk      (clk),
        .reset    (reset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Flush    (Flush),
        .Am       (Am),
        .Pm       (Pm),
        .Ze       (Ze),
        .Pe       (Pe),
        .Ps       (Ps),
        .InvA     (InvA),
        .KillProd (KillProd),
        .ASticky  (ASticky),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Sm       (Sm),
        .Ss       (Ss),
        .Se       (Se)
`ifdef FMAADD_LZC_EN
        ,
        .SmLzc    (SmLzc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_op(input logic [W-1:0] am, input logic [PW-1:0] pm,
                            input logic [NE-1:0] ze, input logic [EW-1:0] pe,
                            input logic ps, input logic inva, input logic kill,
                            input logic ast);
        Am = am; Pm = pm; Ze = ze; Pe = pe;
        Ps = ps; InvA = inva; KillProd = kill; ASticky = ast;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_hs: OutValid=%0b InReady=%0b, required 0/1", OutValid, InReady);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (Sm !== '0 || Ss !== 1'b0 || Se !== '0) begin
            failures++;
            $display("FAIL reset_data: Sm=%0d Ss=%0b Se=%0d, required 0/0/0", Sm, Ss, Se);
        end
`ifdef FMAADD_LZC_EN
        checks++;
        if (SmLzc !== '0) begin
            failures++;
            $display("FAIL reset_lzc: got %0d required 0", SmLzc);
        end
`endif
    endtask

    task automatic test_directed;
        logic [W-1:0]  v_am [8];
        logic [PW-1:0] v_pm [8];
        logic [NE-1:0] v_ze [8];
        logic [EW-1:0] v_pe [8];
        logic [3:0]    v_ctl[8];   // {ps, inva, kill, asticky}
        logic [W-1:0]  e_sm [8];
        logic          e_ss [8];
        logic [EW-1:0] e_se [8];
        int            e_lz [8];
        v_am[0] = 0;    v_pm[0] = 4;  v_ze[0] = 0; v_pe[0] = 100;  v_ctl[0] = 4'b0000;
        e_sm[0] = 16;   e_ss[0] = 0;  e_se[0] = 100;  e_lz[0] = 70;
        v_am[1] = 64;   v_pm[1] = 4;  v_ze[1] = 0; v_pe[1] = 33;   v_ctl[1] = 4'b0100;
        e_sm[1] = 48;   e_ss[1] = 1;  e_se[1] = 33;   e_lz[1] = 69;
        v_am[2] = 100;  v_pm[2] = 77; v_ze[2] = 5; v_pe[2] = 200;  v_ctl[2] = 4'b0010;
        e_sm[2] = 100;  e_ss[2] = 0;  e_se[2] = 5;    e_lz[2] = 68;
        v_am[3] = 4;    v_pm[3] = 4;  v_ze[3] = 0; v_pe[3] = 50;   v_ctl[3] = 4'b0101;
        e_sm[3] = 11;   e_ss[3] = 0;  e_se[3] = 50;   e_lz[3] = 71;
        v_am[4] = 7;    v_pm[4] = 9;  v_ze[4] = 3; v_pe[4] = 1;    v_ctl[4] = 4'b1110;
        e_sm[4] = 7;    e_ss[4] = 0;  e_se[4] = 3;    e_lz[4] = 72;
        v_am[5] = 0;    v_pm[5] = 0;  v_ze[5] = 0; v_pe[5] = 0;    v_ctl[5] = 4'b1000;
        e_sm[5] = 0;    e_ss[5] = 1;  e_se[5] = 0;    e_lz[5] = 75;
        v_am[6] = {1'b1, {(W-1){1'b0}}}; v_pm[6] = 0; v_ze[6] = 0; v_pe[6] = 1023; v_ctl[6] = 4'b0000;
        e_sm[6] = {1'b1, {(W-1){1'b0}}}; e_ss[6] = 0; e_se[6] = 1023; e_lz[6] = 0;
        v_am[7] = 1000; v_pm[7] = 10; v_ze[7] = 0; v_pe[7] = 7;    v_ctl[7] = 4'b0101;
        e_sm[7] = 960;  e_ss[7] = 1;  e_se[7] = 7;    e_lz[7] = 65;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive_op(v_am[i], v_pm[i], v_ze[i], v_pe[i],
                     v_ctl[i][3], v_ctl[i][2], v_ctl[i][1], v_ctl[i][0]);
            InValid  = 1'b1;
            OutReady = 1'b1;
            #1;
            checks++;
            if (InReady !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_inready: got %0b required 1", i, InReady);
            end
            @(negedge clk);
            InValid = 1'b0;
            checks++;
            if (OutValid !== 1'b0) begin
                failures++;
                $display("FAIL dir%0d_early: OutValid=%0b one cycle after accept, required 0", i, OutValid);
            end
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_latency: OutValid=%0b two cycles after accept, required 1", i, OutValid);
            end
            checks++;
            if (Sm !== e_sm[i] || Ss !== e_ss[i] || Se !== e_se[i]) begin
                failures++;
                $display("FAIL dir%0d_result: Sm=%0d Ss=%0b Se=%0d, required Sm=%0d Ss=%0b Se=%0d",
                         i, Sm, Ss, Se, e_sm[i], e_ss[i], e_se[i]);
            end
`ifdef FMAADD_LZC_EN
            checks++;
            if (SmLzc !== LW'(e_lz[i])) begin
                failures++;
                $display("FAIL dir%0d_lzc: got %0d required %0d", i, SmLzc, e_lz[i]);
            end
`endif
        end
    endtask

    task automatic test_back_to_back;
        int            tx;
        int            rx;
        int            occ;
        logic          held;
        logic [W-1:0]  hsm;
        logic          hss;
        logic [EW-1:0] hse;
        tx = 0; rx = 0; held = 1'b0; hsm = '0; hss = 1'b0; hse = '0;
        for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
            @(negedge clk);
            OutReady = !(cyc >= 3 && cyc <= 5);
            InValid  = (tx < 8);
            if (tx < 8) drive_op('0, PW'(tx + 1), '0, EW'(10 + tx), tx[0], 1'b0, 1'b0, 1'b0);
            #1;
            occ = tx - rx;
            checks++;
            if (InReady !== !(occ == 2 && !OutReady)) begin
                failures++;
                $display("FAIL b2b_inready cyc%0d: got %0b required %0b (occupancy %0d)",
                         cyc, InReady, !(occ == 2 && !OutReady), occ);
            end
            if (held) begin
                checks++;
                if (OutValid !== 1'b1 || Sm !== hsm || Ss !== hss || Se !== hse) begin
                    failures++;
                    $display("FAIL b2b_hold cyc%0d: OutValid=%0b Sm=%0d Se=%0d, required 1 Sm=%0d Se=%0d",
                             cyc, OutValid, Sm, Se, hsm, hse);
                end
            end
            held = OutValid && !OutReady;
            if (held) begin
                hsm = Sm; hss = Ss; hse = Se;
            end
            if (OutValid && OutReady) begin
                checks++;
                if (Sm !== W'(4 * (rx + 1)) || Ss !== rx[0] || Se !== EW'(10 + rx)) begin
                    failures++;
                    $display("FAIL b2b_result%0d: Sm=%0d Ss=%0b Se=%0d, required Sm=%0d Ss=%0b Se=%0d",
                             rx, Sm, Ss, Se, 4 * (rx + 1), rx[0], 10 + rx);
                end
                rx++;
            end
            if (InValid && InReady) tx++;
        end
        checks++;
        if (rx != 8) begin
            failures++;
            $display("FAIL b2b_count: received %0d results within budget, required 8", rx);
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_extra: OutValid=%0b after stream drained, required 0", OutValid);
            end
        end
    endtask

    task automatic test_flush;
        @(negedge clk);
        OutReady = 1'b0;
        drive_op('0, PW'(5), '0, EW'(1), 1'b0, 1'b0, 1'b0, 1'b0);
        InValid = 1'b1;
        @(negedge clk);
        drive_op('0, PW'(6), '0, EW'(2), 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive_op('0, PW'(7), '0, EW'(4), 1'b0, 1'b0, 1'b0, 1'b0);
        Flush = 1'b1;
        @(negedge clk);
        Flush    = 1'b0;
        OutReady = 1'b1;
        drive_op('0, PW'(9), '0, EW'(3), 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear: OutValid=%0b InReady=%0b, required 0/1", OutValid, InReady);
        end
        @(negedge clk);
        InValid = 1'b0;
        checks++;
        if (OutValid !== 1'b0) begin
            failures++;
            $display("FAIL flush_stale: OutValid=%0b one cycle after accept, required 0", OutValid);
        end
        @(negedge clk);
        checks++;
        if (OutValid !== 1'b1 || Sm !== W'(36) || Se !== EW'(3)) begin
            failures++;
            $display("FAIL flush_next: OutValid=%0b Sm=%0d Se=%0d, required 1 Sm=36 Se=3", OutValid, Sm, Se);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost: OutValid=%0b Sm=%0d, required 0", OutValid, Sm);
            end
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        OutReady = 1'b0;
        drive_op('0, PW'(3), '0, EW'(55), 1'b1, 1'b0, 1'b0, 1'b0);
        InValid = 1'b1;
        @(negedge clk);
        drive_op('0, PW'(2), '0, EW'(56), 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        InValid = 1'b0;
        #1;
        checks++;
        if (OutValid !== 1'b1 || InReady !== 1'b0 || Sm !== W'(12)) begin
            failures++;
            $display("FAIL arst_full: OutValid=%0b InReady=%0b Sm=%0d, required 1/0/12", OutValid, InReady, Sm);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            failures++;
            $display("FAIL arst_hs: OutValid=%0b InReady=%0b, required 0/1", OutValid, InReady);
        end
        checks++;
        if (Sm !== '0 || Ss !== 1'b0 || Se !== '0) begin
            failures++;
            $display("FAIL arst_data: Sm=%0d Ss=%0b Se=%0d, required 0/0/0", Sm, Ss, Se);
        end
        @(negedge clk);
        reset    = 1'b0;
        OutReady = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (OutValid !== 1'b0) begin
                failures++;
                $display("FAIL arst_stale: OutValid=%0b after release, required 0", OutValid);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        InValid  = 1'b0;
        Flush    = 1'b0;
        OutReady = 1'b1;
        drive_op('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
